// File: rtl/flash_nor_if.sv
// Asynchronous parallel NOR flash bus: initiator (master) and device (slave) views.
interface flash_nor_if;
    logic [24:0] a;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        adv_n;
    logic        rp_n;
    logic        wt_n;
    logic        busy;

    modport master (
        output a, dq_i, ce_n, oe_n, we_n, adv_n, rp_n,
        input  dq_o, dq_oe, wt_n, busy
    );

    modport slave (
        input  a, dq_i, ce_n, oe_n, we_n, adv_n, rp_n,
        output dq_o, dq_oe, wt_n, busy
    );
endinterface

// File: rtl/flash_nor_responder.sv
// Device-side model of an async NOR flash: command decode, word program,
// block erase, status and ID reads over a small word array.
//
// state       | meaning
// IDLE        | decoding command writes
// PROG_SETUP  | 40/10 seen, next write is address+data to program
// ERASE_SETUP | 20 seen, next write must be D0 to confirm
// PROG_BUSY   | program in progress, counting down
// ERASE_BUSY  | wiping block one word per cycle, then counting down
module flash_nor_responder #(
    parameter int          AW        = 12,
    parameter int          BW        = 6,
    parameter int          RD_LAT    = 3,
    parameter int          PROG_CYC  = 20,
    parameter int          ERASE_CYC = 40,
    parameter logic [15:0] DEV_ID    = 16'h8817
) (
    input logic          clk,
    input logic          rst,
    flash_nor_if.slave   bus
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] PROG_SETUP  = 3'd1;
    localparam logic [2:0] ERASE_SETUP = 3'd2;
    localparam logic [2:0] PROG_BUSY   = 3'd3;
    localparam logic [2:0] ERASE_BUSY  = 3'd4;

    localparam logic [1:0] MODE_ARRAY  = 2'd0;
    localparam logic [1:0] MODE_STATUS = 2'd1;
    localparam logic [1:0] MODE_ID     = 2'd2;

    logic [1:0] ce_sync, oe_sync, we_sync, rp_sync;
    logic       ce_s, oe_s, we_s, rp_s, we_prev;
    logic       wr;

    logic [2:0]     state;
    logic [1:0]     mode;
    logic [7:0]     sr;
    logic [15:0]    bcnt;
    logic           walking;
    logic [BW-1:0]  widx;
    logic [AW-BW-1:0] eblk;
    logic           busy_i;

    logic [15:0]    mem [2**AW];
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [15:0]    mem_wdata;
    logic [AW-1:0]  wa;
    logic [15:0]    prog_data;

    logic [15:0]    rd_cnt;
    logic           rd_cond;
    logic [15:0]    rd_data;
    logic [15:0]    dq_o_q;
    logic           dq_oe_q;

    logic           unused_bits;
    assign unused_bits = ^{bus.a[24:AW], bus.adv_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_sync <= 2'b11;
            oe_sync <= 2'b11;
            we_sync <= 2'b11;
            rp_sync <= 2'b11;
            we_prev <= 1'b1;
        end else begin
            ce_sync <= {ce_sync[0], bus.ce_n};
            oe_sync <= {oe_sync[0], bus.oe_n};
            we_sync <= {we_sync[0], bus.we_n};
            rp_sync <= {rp_sync[0], bus.rp_n};
            we_prev <= we_s;
        end
    end

    assign ce_s = ce_sync[1];
    assign oe_s = oe_sync[1];
    assign we_s = we_sync[1];
    assign rp_s = rp_sync[1];

    // Write strobe: rising edge of synced we_n inside a selected cycle, not in device reset
    assign wr        = we_s & ~we_prev & ~ce_s & rp_s;
    assign wa        = bus.a[AW-1:0];
    assign prog_data = mem[wa] & bus.dq_i;
    assign busy_i    = (state == PROG_BUSY) || (state == ERASE_BUSY);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wa;
        mem_wdata = prog_data;
        if (rp_s) begin
            if (state == PROG_SETUP && wr) begin
                mem_we = 1'b1;
            end else if (state == ERASE_BUSY && walking) begin
                mem_we    = 1'b1;
                mem_addr  = {eblk, widx};
                mem_wdata = 16'hFFFF;
            end
        end
    end

    // Array content survives reset, so it lives in a reset-less block
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mode    <= MODE_ARRAY;
            sr      <= 8'h80;
            bcnt    <= '0;
            walking <= 1'b0;
            widx    <= '0;
            eblk    <= '0;
        end else if (!rp_s) begin
            state   <= IDLE;
            mode    <= MODE_ARRAY;
            sr      <= 8'h80;
            bcnt    <= '0;
            walking <= 1'b0;
            widx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr) begin
                        case (bus.dq_i[7:0])
                            8'hFF:        mode    <= MODE_ARRAY;
                            8'h70:        mode    <= MODE_STATUS;
                            8'h90:        mode    <= MODE_ID;
                            8'h50:        sr[5:4] <= 2'b00;
                            8'h40, 8'h10: state   <= PROG_SETUP;
                            8'h20:        state   <= ERASE_SETUP;
                            default:      ;
                        endcase
                    end
                end
                PROG_SETUP: begin
                    if (wr) begin
                        if (prog_data != bus.dq_i) sr[4] <= 1'b1;
                        sr[7] <= 1'b0;
                        mode  <= MODE_STATUS;
                        bcnt  <= 16'(PROG_CYC - 1);
                        state <= PROG_BUSY;
                    end
                end
                ERASE_SETUP: begin
                    if (wr) begin
                        if (bus.dq_i[7:0] == 8'hD0) begin
                            sr[7]   <= 1'b0;
                            mode    <= MODE_STATUS;
                            eblk    <= wa[AW-1:BW];
                            widx    <= '0;
                            walking <= 1'b1;
                            state   <= ERASE_BUSY;
                        end else begin
                            sr[5:4] <= 2'b11;
                            state   <= IDLE;
                        end
                    end
                end
                PROG_BUSY: begin
                    if (bcnt == 16'd0) begin
                        sr[7] <= 1'b1;
                        state <= IDLE;
                    end else begin
                        bcnt <= bcnt - 16'd1;
                    end
                end
                ERASE_BUSY: begin
                    if (walking) begin
                        if (widx == '1) begin
                            walking <= 1'b0;
                            bcnt    <= 16'(ERASE_CYC - 1);
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end else if (bcnt == 16'd0) begin
                        sr[7] <= 1'b1;
                        state <= IDLE;
                    end else begin
                        bcnt <= bcnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_cond = ~ce_s & ~oe_s & we_s;

    always_comb begin
        rd_data = mem[wa];
        if (busy_i || mode == MODE_STATUS) rd_data = {8'h00, sr};
        else if (mode == MODE_ID)          rd_data = bus.a[0] ? DEV_ID : 16'h0089;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= 16'(RD_LAT - 1);
            dq_oe_q <= 1'b0;
            dq_o_q  <= '0;
        end else begin
            dq_o_q <= rd_data;
            if (!rd_cond) begin
                rd_cnt  <= 16'(RD_LAT - 1);
                dq_oe_q <= 1'b0;
            end else if (rd_cnt == 16'd0) begin
                dq_oe_q <= 1'b1;
            end else begin
                rd_cnt <= rd_cnt - 16'd1;
            end
        end
    end

    assign bus.dq_o  = dq_o_q;
    assign bus.dq_oe = dq_oe_q;
    assign bus.wt_n  = ~busy_i;
    assign bus.busy  = busy_i;
endmodule

// File: doc/flash_nor_responder.md
Name: flash_nor_responder

Overview:
- Synthesizable responder for the asynchronous parallel NOR flash bus: the device end of the bus driven by our flash interface block.
- Sits in the simulation/emulation harness in place of the external flash part.
- Decodes CFI/Intel-style command cycles and models a small word array with word program, block erase, status register and ID reads.
- Lets the controller (erase/prog/read, wait handling) be exercised on-chip or in simulation without the real device.

Parameters:
AW, 12, modelled array address width in words (depth 2**AW); upper address bits ignored
BW, 6, block address width (block = 2**BW words)
RD_LAT, 3, clk cycles from synced ce_n&oe_n low to dq_oe high
PROG_CYC, 20, busy cycles for a word program
ERASE_CYC, 40, extra busy cycles after the block wipe walk
DEV_ID, 16'h8817, value returned at ID offset 1

Ports:
clk  in  1  sampling/model clock; must be ≥4x the bus strobe rate
rst  in  1  async active-high reset
a  in  25  bus address
dq_i  in  16  bus data from initiator
dq_o  out  16  data to initiator
dq_oe  out  1  drive enable for dq_o (tristate at top level)
ce_n  in  1  chip enable, active low
oe_n  in  1  output enable, active low
we_n  in  1  write enable, active low
adv_n  in  1  address valid; async mode only, ignored
rp_n  in  1  device reset pin, active low
wt_n  out  1  ready/busy, low while program or erase in progress
busy  out  1  debug copy of ~wt_n

Behaviour:
- Reset (rst):
  - dq_o=0, dq_oe=0, wt_n=1, busy=0.
  - Read mode ARRAY, SR=8'h80, FSM IDLE.
  - Array contents are NOT reset.
- Input sync: ce_n, oe_n, we_n and rp_n each pass through 2 flops.
- Write cycle:
  - Detected on the synced we_n rising edge while synced ce_n=0.
  - a and dq_i are captured in that same cycle; the initiator holds them ≥3 clk past we_n high.
- Read path:
  - dq_oe rises RD_LAT clk after synced ce_n=0 && oe_n=0 && we_n=1.
  - dq_oe falls on the first cycle the synced condition is false.
  - dq_o is updated every cycle from the live a, per read mode:
    - ARRAY: mem[a[AW-1:0]].
    - STATUS: {8'h00,SR}.
    - ID: offset a[0]=0 → 16'h0089, a[0]=1 → DEV_ID.
  - While busy, reads always return STATUS regardless of mode.
- SR bits: SR7 ready, SR5 erase/sequence error, SR4 program error. All other bits 0.
- FSM states: IDLE, PROG_SETUP, ERASE_SETUP, PROG_BUSY, ERASE_BUSY.
- IDLE command decode on dq_i[7:0]:
  - FF → mode ARRAY.
  - 70 → mode STATUS.
  - 90 → mode ID.
  - 50 → SR[5:4]=0.
  - 40 or 10 → PROG_SETUP.
  - 20 → ERASE_SETUP.
  - Any other value → ignored, no state change.
- PROG_SETUP, next write (addr, data):
  - new = mem & data.
  - SR4 set if new≠data (attempt to program 0→1).
  - Store new. Go to PROG_BUSY and count PROG_CYC cycles.
- ERASE_SETUP, next write:
  - D0 → ERASE_BUSY on block a[AW-1:BW]. Write 16'hFFFF to one word per cycle (word offset 0…2**BW-1), then wait ERASE_CYC cycles.
  - Any other data → SR5=SR4=1, back to IDLE, no erase.
- Entering either BUSY state: SR7=0, wt_n=0, mode=STATUS.
- Leaving either BUSY state: SR7=1, wt_n=1, return to IDLE. Mode stays STATUS.
- Write cycles during BUSY are ignored entirely, including FF.
- rp_n low (synced), highest priority:
  - Abort any operation, FSM IDLE, mode ARRAY, SR=8'h80, wt_n=1.
  - Erase words already wiped stay FFFF; the remainder of the block is unchanged.
  - Write strobes are ignored while rp_n is low.
- A write strobe and a busy-counter expiry in the same cycle: the write is ignored (still BUSY that cycle).
- Address arithmetic: bits of a above AW-1 are discarded, so the array aliases modulo 2**AW.

Test Plan:
- Erase: write 20@0x040, D0@0x040, poll reads → wt_n low ~(64+40) clk; status 0x0080 when done; FF, then reads 0x040–0x07F = 0xFFFF, 0x03F unchanged.
- Program: after erase, write 40@0x041, 0x1234@0x041 → SR7=0 for 20 clk, then status 0x0080; FF, read 0x041 = 0x1234.
- Program error: program 0xFFFF over 0x1234 at 0x041 → SR=0x90, word stays 0x1234; 50 clears to 0x80.
- Sequence error: 20@0x000 then 0xAA → SR=0xB0, no erase, wt_n never low.
- ID / read latency: 90 then read a=0 → 0x0089, a=1 → 0x8817; dq_oe rises exactly 2+RD_LAT clk after oe_n falls and is 0 within 3 clk of oe_n rising.
- Abort: start erase at 0x080, pulse rp_n low 4 clk mid-walk → wt_n=1, mode ARRAY, SR=0x80; early block words FFFF, later words keep prior values; rst mid-program → outputs back to reset values.
